sdiv_seq: RTL and testbench
===========================

// Module: sdiv_seq
// PURPOSE
//  Multi-cycle signed restoring divider: repeated compare-and-subtract, inverse use of the subtract/less-than datapath.
//  Accepts one signed dividend/divisor pair on a start pulse; returns quotient, remainder and status after fixed latency.
//  Sits beside the combinational ALU blocks as the long-latency divide unit; one operation in flight.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; iteration count = WIDTH; latency = WIDTH+2 cycles
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  x      in   WIDTH  signed dividend, sampled with start
//  y      in   WIDTH  signed divisor, sampled with start
//  busy   out  1      operation in progress (PREP/ITER/FIX)
//  done   out  1      result valid; held until next accepted start or rst
//  q      out  WIDTH  signed quotient, truncated toward zero
//  r      out  WIDTH  signed remainder, sign of dividend, |r| < |y|
//  dz     out  1      divide by zero flag
//  ovf    out  1      overflow flag (min_int / -1)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, q, r, dz, ovf = 0. rst in any state (incl. mid-ITER) aborts; result discarded.
//  - States: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE; DONE -> PREP on start, else hold.
//  - Accept edge E0 (start=1 in IDLE/DONE): latch x, y; clear done, q, r, dz, ovf; busy=1 from E0.
//  - PREP (edge E1): form unsigned magnitudes |x|, |y| (WIDTH-bit unsigned; |min_int| = 2^(WIDTH-1) representable);
//    record sign_q = x[MSB]^y[MSB], sign_r = x[MSB]; set dz = (y==0), ovf = (x==min_int && y==-1).
//  - ITER (edges E2..E(WIDTH+1)): partial remainder P (WIDTH+1 bits) shifts in next dividend bit MSB-first;
//    if P >= |y| then P -= |y|, quotient bit = 1, else 0. Iteration counter 0..WIDTH-1, exits at WIDTH-1.
//  - FIX (edge E(WIDTH+2)): negate quotient if sign_q, remainder if sign_r (two's complement, WIDTH-bit wrap);
//    load q, r; busy=0, done=1. Outputs valid from E(WIDTH+2): 10 cycles after E0 for WIDTH=8.
//  - Divide by zero: iterations run (result ignored); final q = all ones (-1), r = x, dz=1, ovf=0.
//  - Overflow: min_int / -1 -> q = min_int (wrap), r = 0, ovf=1, dz=0.
//  - start while busy: ignored, no effect on state or operands.
//  - start in DONE: accepted as new op (same cycle as done drop at E0).
//  - x, y changes after E0 have no effect; results registered, never combinational from inputs.
// CONFIGURATION
//  SDIV_SEQ_EARLY_DZ_EN
//   defined:   y==0 detected in PREP; PREP -> DONE directly; done=1, dz=1, q=-1, r=x from E1 (latency 2 edges
//              after accept incl. E0); other cases unchanged.
//   undefined: fixed latency WIDTH+2 for every operand pair, including y==0.
// TESTING (WIDTH=8)
//  1. x=100, y=7, start 1 cycle -> done at E10: q=14 (8'h0E), r=2, dz=0, ovf=0; busy=1 E0..E9.
//  2. x=-100, y=7 -> q=-14 (8'hF2), r=-2 (8'hFE); x=100, y=-7 -> q=8'hF2, r=2.
//  3. x=-128, y=-1 -> q=8'h80, r=0, ovf=1; x=-128, y=2 -> q=-64 (8'hC0), r=0; x=5, y=-128 -> q=0, r=5.
//  4. x=37, y=0 -> dz=1, q=8'hFF, r=37; done at E10 (E1 with SDIV_SEQ_EARLY_DZ_EN).
//  5. start=1 held continuously with new x,y at E3 -> ignored until DONE; next op re-accepted in DONE state.
//  6. rst=1 at E5 mid-ITER -> IDLE, all outputs 0 next edge; following start x=9, y=3 -> q=3, r=0 at +10.

Source files
------------

// File: rtl/sdiv_seq.sv
// ============================================================================
//  Module   : sdiv_seq
//  Purpose  : Multi-cycle signed restoring divider (quotient truncates toward
//             zero, remainder takes the dividend's sign). One op in flight.
//  Option   : SDIV_SEQ_EARLY_DZ_EN - finish divide-by-zero straight from PREP.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic             ovf
);

  localparam int               c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_dq;     // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0]   r_ymag;
  logic [WIDTH-1:0]   r_p;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic               r_dz;
  logic               r_ovf;

  logic             w_accept;
  logic [WIDTH-1:0] w_xmag;
  logic [WIDTH-1:0] w_ymag;
  logic             w_is_dz;
  logic             w_is_ovf;
  logic [WIDTH:0]   w_p_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Magnitude of min_int wraps to 2^(WIDTH-1), which is exact as unsigned.
  assign w_xmag   = r_x[WIDTH-1] ? (-r_x) : r_x;
  assign w_ymag   = r_y[WIDTH-1] ? (-r_y) : r_y;
  assign w_is_dz  = (r_y == '0);
  assign w_is_ovf = (r_x == c_MIN_INT) && (r_y == c_ALL_ONES);

  // Trial subtract; a clear borrow bit means P >= |y|.
  assign w_p_sh = {r_p, r_dq[WIDTH-1]};
  assign w_diff = w_p_sh - {1'b0, r_ymag};
  assign w_qbit = ~w_diff[WIDTH];

  always_comb begin
    w_q_fix = r_sign_q ? (-r_dq) : r_dq;
    w_r_fix = r_sign_r ? (-r_p) : r_p;
    if (r_dz) begin
      w_q_fix = c_ALL_ONES;
      w_r_fix = r_x;
    end else if (r_ovf) begin
      w_q_fix = c_MIN_INT;
      w_r_fix = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_PREP;
      S_PREP: begin
`ifdef SDIV_SEQ_EARLY_DZ_EN
        if (w_is_dz) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ITER;
        end
`else
        w_state_nxt = S_ITER;
`endif
      end
      S_ITER: if (r_cnt == c_LAST) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (start) w_state_nxt = S_PREP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_dq     <= '0;
      r_ymag   <= '0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_x    <= x;
            r_y    <= y;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_PREP: begin
          r_dq     <= w_xmag;
          r_ymag   <= w_ymag;
          r_p      <= '0;
          r_cnt    <= '0;
          r_sign_q <= r_x[WIDTH-1] ^ r_y[WIDTH-1];
          r_sign_r <= r_x[WIDTH-1];
          r_dz     <= w_is_dz;
          r_ovf    <= w_is_ovf;
`ifdef SDIV_SEQ_EARLY_DZ_EN
          if (w_is_dz) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_q    <= c_ALL_ONES;
            r_r    <= r_x;
          end
`endif
        end
        S_ITER: begin
          r_p   <= w_qbit ? w_diff[WIDTH-1:0] : w_p_sh[WIDTH-1:0];
          r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_q    <= w_q_fix;
          r_r    <= w_r_fix;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign dz   = r_dz;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sdiv_seq.sv
// ============================================================================
//  Module   : tb_sdiv_seq
//  Purpose  : Directed self-checking bench for sdiv_seq (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdiv_seq;

`ifdef SDIV_SEQ_EARLY_DZ_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       dz;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  sdiv_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Present one start pulse; returns at the falling edge after the accept edge.
  task automatic issue(input logic [7:0] xi, input logic [7:0] yi);
    @(negedge clk);
    start = 1'b1;
    x     = xi;
    y     = yi;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Rising edges after the accept edge until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, dz, ovf, q, r} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h, want all 0",
               busy, done, dz, ovf, q, r);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int lat;
    issue(8'd100, 8'd7);
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) lat = i;
    end
    n_tests++;
    if (lat != 0) begin
      n_fail++;
      $display("FAIL basic_busy_window: busy/done wrong after edge %0d, want busy=1 done=0 through E9", lat);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, dz, ovf} !== 4'b0100 || q !== 8'h0E || r !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_result_E10: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h, want 0 1 0 0 q=0e r=02",
               busy, done, dz, ovf, q, r);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || q !== 8'h0E || r !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_done_hold: got done=%b q=%h r=%h, want 1 0e 02", done, q, r);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] vx[11]  = '{8'h9C, 8'h64, 8'h80, 8'h80, 8'h05, 8'h25, 8'hF9, 8'h7F, 8'h80, 8'h00, 8'h80};
    logic [7:0] vy[11]  = '{8'h07, 8'hF9, 8'hFF, 8'h02, 8'h80, 8'h00, 8'h02, 8'h01, 8'h7F, 8'h05, 8'h00};
    logic [7:0] vq[11]  = '{8'hF2, 8'hF2, 8'h80, 8'hC0, 8'h00, 8'hFF, 8'hFD, 8'h7F, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] vr[11]  = '{8'hFE, 8'h02, 8'h00, 8'h00, 8'h05, 8'h25, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80};
    logic       vdz[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       vov[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    int want_lat;
    for (int i = 0; i < 11; i++) begin
      issue(vx[i], vy[i]);
      n_tests++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL vec%0d_accept: got busy=%b done=%b, want 1 0", i, busy, done);
      end
      wait_done(lat);
      want_lat = vdz[i] ? DZ_LAT : 10;
      n_tests++;
      if (lat != want_lat) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d edges, want %0d", i, lat, want_lat);
      end
      n_tests++;
      if (q !== vq[i] || r !== vr[i] || dz !== vdz[i] || ovf !== vov[i] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_result x=%h y=%h: got q=%h r=%h dz=%b ovf=%b busy=%b, want q=%h r=%h dz=%b ovf=%b busy=0",
                 i, vx[i], vy[i], q, r, dz, ovf, busy, vq[i], vr[i], vdz[i], vov[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    start = 1'b1; x = 8'd100; y = 8'd7;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    x = 8'h9C;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || q !== 8'h0E || r !== 8'h02) begin
      n_fail++;
      $display("FAIL held_start_first: got done=%b q=%h r=%h, want 1 0e 02", done, q, r);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL held_start_reaccept: got busy=%b done=%b, want 1 0", busy, done);
    end
    start = 1'b0;
    wait_done(lat);
    n_tests++;
    if (lat != 10 || q !== 8'hF2 || r !== 8'hFE) begin
      n_fail++;
      $display("FAIL held_start_second: got lat=%0d q=%h r=%h, want 10 f2 fe", lat, q, r);
    end
  endtask

  task automatic test_reset_mid_iter;
    int lat;
    issue(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({busy, done, dz, ovf, q, r} !== 20'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b dz=%b ovf=%b q=%h r=%h, want all 0",
               busy, done, dz, ovf, q, r);
    end
    repeat (12) @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got busy=%b done=%b, want 0 0", busy, done);
    end
    issue(8'd9, 8'd3);
    wait_done(lat);
    n_tests++;
    if (lat != 10 || q !== 8'h03 || r !== 8'h00 || dz !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_next_op: got lat=%0d q=%h r=%h dz=%b ovf=%b, want 10 03 00 0 0",
               lat, q, r, dz, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_while_busy();
    test_reset_mid_iter();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
